voice_allocator: RTL
====================

Name: voice_allocator

Overview:
- Polyphonic voice controller sitting between the note-event source (MIDI/keyboard decoder) and a bank of NUM_VOICES oscillator instances.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice.
- Drives per-voice half_period, wave_select and a one-cycle phase-restart reset; steals the oldest voice when all voices are busy.

Parameters:
- NUM_VOICES, 4, number of oscillator voices driven (2..8).
- VIDX_W, 2, width of a voice index; must equal clog2(NUM_VOICES).
- AGE_W, 8, width of each per-voice saturating age counter.

Ports:
- clk  input  1  fast system clock.
- resetn  input  1  asynchronous, active-low reset.
- enable  input  1  one-cycle audio-tick strobe, same strobe the oscillators receive.
- ev_valid  input  1  event present.
- ev_ready  output  1  allocator can accept an event.
- ev_note_on  input  1  1 = note-on, 0 = note-off.
- ev_note  input  7  note number.
- ev_half_period  input  16  oscillator half period for note-on.
- ev_wave  input  2  wave_select for note-on.
- voice_half_period  output  16*NUM_VOICES  per-voice half period; voice i occupies bits [16i+15:16i].
- voice_wave  output  2*NUM_VOICES  per-voice wave_select.
- voice_active  output  NUM_VOICES  voice gate, for the mixer.
- voice_resetn  output  NUM_VOICES  active-low, one-cycle phase restart to each oscillator.
- ev_dropped  output  1  one-cycle pulse when an accepted event caused no change.

Behaviour:
Reset:
- FSM=IDLE, ev_ready=1 after reset release (0 while resetn low).
- All voice_active=0, voice_half_period=16'hFFFF, voice_wave=0, voice_resetn all 1, ages=0, ev_dropped=0.

FSM:
- IDLE: ev_ready=1. On ev_valid&&ev_ready, latch note_on/note/half_period/wave and go to SCAN with idx=0.
- SCAN: examines one voice per clk, idx 0..NUM_VOICES-1, then goes to COMMIT. ev_ready=0.
- COMMIT: applies the result in one cycle, then returns to IDLE. ev_ready=0.
- Latency: accept edge to COMMIT edge = NUM_VOICES+1 clks. Next accept is possible NUM_VOICES+2 clks after the previous one.

Note-on selection, in priority order:
- (a) An active voice with the same note: retrigger it.
- (b) The lowest-index inactive voice.
- (c) With stealing enabled, the active voice with the largest age; ties go to the lowest index.

On commit for the selected voice:
- Load half_period and wave; set active=1; clear age to 0.
- Drive voice_resetn[i]=0 for exactly the COMMIT cycle.

Note-off:
- The lowest-index active voice whose note matches gets active=0.
- half_period and wave are held; no voice_resetn pulse.
- No match: no change, ev_dropped pulses in COMMIT.

Note-on with ev_half_period==0:
- Rejected; no voice change (protects the oscillator slope divide). ev_dropped pulses in COMMIT.

Ages:
- On enable, every active voice's age increments, saturating at 2^AGE_W-1. Inactive ages hold.
- Age clear on commit takes precedence over a same-cycle increment.
- SCAN compares live age values; an enable during SCAN is legal.

Other:
- ev_dropped is asserted only in the COMMIT cycle, otherwise 0.
- ev_* inputs are ignored when not in IDLE.
- Reset asserted mid-SCAN/COMMIT aborts the event; it is not replayed.

Optional Feature:
- VOICE_STEAL_EN defined: rule (c) is applied. A note-on with all voices busy steals the oldest voice; ev_dropped is not pulsed.
- VOICE_STEAL_EN undefined: rule (c) is omitted. A note-on with no match and no free voice makes no change, and ev_dropped pulses in COMMIT.

Test Plan:
1. After reset, note-on note=60, hp=100, wave=0 -> voice 0: active=1, half_period=100, voice_resetn[0] low exactly 1 clk at accept+5 clks (NUM_VOICES=4); ev_ready low 5 clks.
2. Note-on 60, 62, 64, 67 -> voices 0..3 active; note-off 62 -> voice_active=4'b1101, voice_half_period[1] unchanged, no restart pulse.
3. Four notes held, 3 enables between successive note-ons, then note-on 72 hp=50 -> with VOICE_STEAL_EN voice 0 reloaded to 50 and restarted, ev_dropped=0; without the macro no change and ev_dropped=1 for 1 clk.
4. Note-on 60 twice (second with hp=200) -> same voice retriggered with hp=200; only one voice active.
5. Note-on hp=0 -> no voice change, ev_dropped pulse; note-off for an unheld note 99 -> ev_dropped pulse.
6. Assert resetn low during SCAN -> all outputs return to reset values immediately; after release ev_ready=1 and the aborted event leaves no voice active.

Source files
------------

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans the voices one per clock and commits each note event to one oscillator voice.
// Define VOICE_STEAL_EN to steal the oldest busy voice when a note-on finds no free voice.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2,
    parameter int AGE_W      = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic                     ev_note_on,
    input  logic [6:0]               ev_note,
    input  logic [15:0]              ev_half_period,
    input  logic [1:0]               ev_wave,
    output logic [16*NUM_VOICES-1:0] voice_half_period,
    output logic [2*NUM_VOICES-1:0]  voice_wave,
    output logic [NUM_VOICES-1:0]    voice_active,
    output logic [NUM_VOICES-1:0]    voice_resetn,
    output logic                     ev_dropped
);
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [AGE_W-1:0]  AGE_MAX  = '1;
    localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

    state_t            state;
    logic [VIDX_W-1:0] idx;
    logic              lat_on;
    logic [6:0]        lat_note;
    logic [15:0]       lat_hp;
    logic [1:0]        lat_wave;
    logic              match_found;
    logic              free_found;
    logic [VIDX_W-1:0] match_idx;
    logic [VIDX_W-1:0] free_idx;
`ifdef VOICE_STEAL_EN
    logic              best_found;
    logic [VIDX_W-1:0] best_idx;
    logic [AGE_W-1:0]  best_age;
`endif
    logic [6:0]        note_q [NUM_VOICES];
    logic [AGE_W-1:0]  age_q  [NUM_VOICES];

    logic              commit_load;
    logic              commit_off;
    logic              commit_drop;
    logic [VIDX_W-1:0] commit_sel;

    assign ev_ready = (state == IDLE) && resetn;

    // Resolve the scan results into a single action for the COMMIT cycle.
    always_comb begin
        commit_load = 1'b0;
        commit_off  = 1'b0;
        commit_drop = 1'b0;
        commit_sel  = match_idx;
        if (state == COMMIT) begin
            if (lat_on) begin
                if (lat_hp == 16'd0) begin
                    commit_drop = 1'b1;
                end else if (match_found) begin
                    commit_load = 1'b1;
                end else if (free_found) begin
                    commit_load = 1'b1;
                    commit_sel  = free_idx;
                end else begin
`ifdef VOICE_STEAL_EN
                    commit_load = 1'b1;
                    commit_sel  = best_idx;
`else
                    commit_drop = 1'b1;
`endif
                end
            end else if (match_found) begin
                commit_off = 1'b1;
            end else begin
                commit_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= IDLE;
            idx               <= '0;
            lat_on            <= 1'b0;
            lat_note          <= '0;
            lat_hp            <= '0;
            lat_wave          <= '0;
            match_found       <= 1'b0;
            free_found        <= 1'b0;
            match_idx         <= '0;
            free_idx          <= '0;
`ifdef VOICE_STEAL_EN
            best_found        <= 1'b0;
            best_idx          <= '0;
            best_age          <= '0;
`endif
            voice_half_period <= {NUM_VOICES{16'hFFFF}};
            voice_wave        <= '0;
            voice_active      <= '0;
            voice_resetn      <= '1;
            ev_dropped        <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            voice_resetn <= '1;
            ev_dropped   <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (enable && voice_active[i] && (age_q[i] != AGE_MAX)) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (ev_valid) begin
                        lat_on      <= ev_note_on;
                        lat_note    <= ev_note;
                        lat_hp      <= ev_half_period;
                        lat_wave    <= ev_wave;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
`ifdef VOICE_STEAL_EN
                        best_found  <= 1'b0;
`endif
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    // First hit wins, so each search yields the lowest matching index.
                    if (voice_active[idx] && (note_q[idx] == lat_note) && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= idx;
                    end
                    if (!voice_active[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
`ifdef VOICE_STEAL_EN
                    if (voice_active[idx] && (!best_found || (age_q[idx] > best_age))) begin
                        best_found <= 1'b1;
                        best_idx   <= idx;
                        best_age   <= age_q[idx];
                    end
`endif
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                COMMIT: begin
                    if (commit_load) begin
                        voice_half_period[16*commit_sel +: 16] <= lat_hp;
                        voice_wave[2*commit_sel +: 2]          <= lat_wave;
                        voice_active[commit_sel]               <= 1'b1;
                        voice_resetn[commit_sel]               <= 1'b0;
                        note_q[commit_sel]                     <= lat_note;
                        age_q[commit_sel]                      <= '0;
                    end
                    if (commit_off) begin
                        voice_active[commit_sel] <= 1'b0;
                    end
                    ev_dropped <= commit_drop;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
